l0_loader: RTL and testbench
============================

# l0_loader

Read-side DMA stage that streams activation words from the single-port activation SRAM into the L0 input buffer in front of the systolic array. On a start pulse it issues `num_rows` sequential SRAM reads from `base_addr` and absorbs the SRAM's one-cycle read latency in a two-entry holding buffer. It forwards words to L0 in order, obeying L0's `o_ready` back-pressure with no loss or duplication, and pulses `done` when the last word has been written.

## Interface
- `col`, 8, lanes per SRAM word / L0 FIFOs
- `bw`, 4, bits per lane
- `addr_bw`, 11, SRAM address width
- `clk` in 1: single clock, all state on posedge
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle request; sampled only in IDLE
- `base_addr` in `addr_bw`: first SRAM address, latched on accepted start
- `num_rows` in `addr_bw`: words to transfer, latched on accepted start
- `busy` out 1: transfer in progress
- `done` out 1: one-cycle completion pulse
- `sram_cen` out 1: SRAM chip enable, active-low
- `sram_wen` out 1: SRAM write enable, active-low; tied 1 (read only)
- `sram_addr` out `addr_bw`: read address
- `sram_q` in `bw*col`: read data, valid the cycle after `sram_cen`=0
- `l0_wr` out 1: write strobe to L0 `wr`
- `l0_in` out `bw*col`: data to L0 `in`
- `l0_ready` in 1: L0 `o_ready`; high when no L0 FIFO is full

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: `start`=1 latches `base_addr` and `num_rows` and clears the issue count. If `num_rows`=0, `done` pulses next cycle and the FSM stays in IDLE; otherwise it goes to RUN.
- RUN: issue a read (`sram_cen`=0, `sram_addr`=base+issued) when `occ + inflight - pop < 2`. `occ` is holding-buffer occupancy, `inflight` is the read issued last cycle, `pop` is `l0_wr` this cycle. When issued equals `num_rows` after an issue, go to DRAIN.
- DRAIN: no reads. When `occ`=0 and `inflight`=0, go to IDLE and pulse `done`.
- Returning `sram_q` is pushed into the 2-entry FIFO-ordered holding buffer at the edge ending its valid cycle.
- `l0_wr` = buffer non-empty AND `l0_ready`, combinational. `l0_in` = buffer head, combinational.
- Address arithmetic is modulo 2^`addr_bw`; it wraps from all-ones to 0.
- `start` while `busy` is ignored. `start` in the same cycle as `done` is accepted (FSM is in IDLE).
- `busy`=1 in RUN and DRAIN.
- Reset at any time:
  - state becomes IDLE; buffer, counters and in-flight flag clear.
  - buffered data is discarded and no `done` is produced.
- Reset values of outputs: `busy`=0, `done`=0, `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `l0_wr`=0, `l0_in`=0.

## Timing
- `start` sampled at edge 0 → RUN in cycle 1, `busy`=1.
- With `l0_ready`=1 throughout:
  - reads issue in cycles 1..N at base..base+N-1.
  - `l0_wr` is high in cycles 3..N+2, words in address order.
  - `done` is high in cycle N+3 and `busy` drops in the same cycle.
- Steady-state throughput is 1 word/cycle; latency from read issue to L0 write is 2 cycles.
- `l0_ready` low: no `l0_wr`. The buffer fills to at most 2 and reads stall within 1 cycle, so there is never overflow. Writes resume the cycle `l0_ready` rises.
- The L0 read side (`rd`) is not driven here.

## Structure
- Shared package/header: FSM state encodings (IDLE/RUN/DRAIN), default `col`/`bw`/`addr_bw`, SRAM word width `bw*col`.
- One sub-module: `skid_buf2`, a 2-entry synchronous FIFO with push/pop, `occ`, head output, and async reset. The FSM, address counter and issue logic stay in `l0_loader`.

## Test plan
- `base_addr`=0x010, `num_rows`=4, `l0_ready`=1, SRAM model returns data=addr → addresses 0x010–0x013 in cycles 1–4; `l0_wr` cycles 3–6 carrying 0x010..0x013; `done` cycle 7.
- `num_rows`=8, `l0_ready`=0 during cycles 4–7 → never more than 2 words held; `sram_cen` stalls; exactly 8 writes, in order; `done` 1 cycle after the last write.
- `base_addr`=0x7FE, `num_rows`=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
- `num_rows`=0 → `done` in cycle 1; `busy` never high; `sram_cen` stays 1.
- `reset` pulsed mid-RUN after 3 writes → all outputs take reset values immediately and no `done`. A new start with `base_addr`=0x100, `num_rows`=2 then reads 0x100–0x101 cleanly.
- Second `start` pulse while `busy` → ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/l0_loader_pkg.sv
// Shared definitions for the activation-SRAM to L0 loader: FSM encoding
// and default geometry of the SRAM word.
package l0_loader_pkg;

    localparam int DEF_COL     = 8;
    localparam int DEF_BW      = 4;
    localparam int DEF_ADDR_BW = 11;
    localparam int DEF_WORD_BW = DEF_BW * DEF_COL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/l0_loader_skid_buf2.sv
// Two-entry FIFO that soaks up SRAM words returning after their one-cycle
// read latency, so L0 back-pressure never drops a word already in flight.
module skid_buf2
    import l0_loader_pkg::*;
#(
    parameter int width = DEF_WORD_BW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] head,
    output logic [1:0]       occ
);

    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/l0_loader.sv
// Read-side DMA: streams num_rows words from the activation SRAM starting at
// base_addr into the L0 input buffer, honouring L0 back-pressure.
module l0_loader
    import l0_loader_pkg::*;
#(
    parameter int col     = DEF_COL,
    parameter int bw      = DEF_BW,
    parameter int addr_bw = DEF_ADDR_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [addr_bw-1:0] num_rows,
    output logic               busy,
    output logic               done,
    output logic               sram_cen,
    output logic               sram_wen,
    output logic [addr_bw-1:0] sram_addr,
    input  logic [bw*col-1:0]  sram_q,
    output logic               l0_wr,
    output logic [bw*col-1:0]  l0_in,
    input  logic               l0_ready
);

    state_t             state;
    state_t             state_next;
    logic [addr_bw-1:0] base_q;
    logic [addr_bw-1:0] rows_q;
    logic [addr_bw-1:0] issued;
    logic [addr_bw-1:0] issued_inc;
    logic               inflight;
    logic               done_q;
    logic               done_set;
    logic               issue;
    logic               pop;
    logic               accept;
    logic               drain_empty;
    logic [1:0]         occ;
    logic [bw*col-1:0]  head;

    skid_buf2 #(
        .width (bw * col)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (sram_q),
        .head  (head),
        .occ   (occ)
    );

    assign pop        = (occ != 2'd0) && l0_ready;
    assign l0_wr      = pop;
    assign l0_in      = head;
    assign accept     = (state == IDLE) && start;
    assign issued_inc = issued + 1'b1;

    // Only issue when the word it returns is guaranteed a slot in the buffer.
    assign issue = (state == RUN) && (issued != rows_q) &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    // True when the buffer will be empty and nothing returns next cycle.
    assign drain_empty = ((occ + {1'b0, inflight}) == {1'b0, pop});

    assign sram_cen  = ~issue;
    assign sram_wen  = 1'b1;
    assign sram_addr = base_q + issued;
    assign busy      = (state != IDLE);
    assign done      = done_q;

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (issue && (issued_inc == rows_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            rows_q   <= '0;
            issued   <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            done_q   <= done_set;
            inflight <= issue;
            if (accept) begin
                base_q <= base_addr;
                rows_q <= num_rows;
                issued <= '0;
            end else if (issue) begin
                issued <= issued_inc;
            end
        end
    end

endmodule

// File: tb/tb_l0_loader.sv
// Scoreboard bench for l0_loader: expected read addresses and L0 words are
// queued at start, and a negedge monitor checks them as the DUT emits them.
module tb_l0_loader;

    localparam int WBW = 32;
    localparam int ABW = 11;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [ABW-1:0] base_addr;
    logic [ABW-1:0] num_rows;
    logic           busy;
    logic           done;
    logic           sram_cen;
    logic           sram_wen;
    logic [ABW-1:0] sram_addr;
    logic [WBW-1:0] sram_q;
    logic           l0_wr;
    logic [WBW-1:0] l0_in;
    logic           l0_ready;

    l0_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_q    (sram_q),
        .l0_wr     (l0_wr),
        .l0_in     (l0_in),
        .l0_ready  (l0_ready)
    );

    always #5 clk = ~clk;

    // SRAM model: data equals address, one cycle after the read.
    always @(posedge clk) begin
        if (!sram_cen) sram_q <= {{(WBW-ABW){1'b0}}, sram_addr};
        else           sram_q <= 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [ABW-1:0] exp_addr [$];
    logic [WBW-1:0] exp_data [$];

    int c0, n_rd, n_wr, first_rd, last_rd, first_wr, last_wr;
    int done_count, done_rel, max_hold, rd_win, win_lo, win_hi;
    logic busy_at_done, busy_seen;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        done_count = 0; done_rel = -1; max_hold = 0; rd_win = 0;
        busy_at_done = 1'b0; busy_seen = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT reads SRAM or writes L0.
    always @(negedge clk) begin
        if (!reset) begin
            int rel;
            rel = cyc - c0;
            if (n_rd - n_wr > max_hold) max_hold = n_rd - n_wr;
            if (busy) busy_seen = 1'b1;
            if (!sram_cen) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("[TB] FAIL rd_unexpected: got addr 0x%0h, expected no read", sram_addr);
                end else begin
                    check("rd_addr", 32'(sram_addr), 32'(exp_addr.pop_front()));
                end
                if (n_rd == 0) first_rd = rel;
                last_rd = rel;
                n_rd++;
                if (rel >= win_lo && rel <= win_hi) rd_win++;
            end
            if (l0_wr) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("[TB] FAIL wr_unexpected: got 0x%0h, expected no write", l0_in);
                end else begin
                    check("wr_data", l0_in, exp_data.pop_front());
                end
                if (n_wr == 0) first_wr = rel;
                last_wr = rel;
                n_wr++;
            end
            if (done) begin
                done_count++;
                done_rel = rel;
                busy_at_done = busy;
            end
        end
    end

    task automatic push_expected(input logic [ABW-1:0] base, input logic [ABW-1:0] rows);
        logic [ABW-1:0] a;
        for (int i = 0; i < int'(rows); i++) begin
            a = base + ABW'(i);
            exp_addr.push_back(a);
            exp_data.push_back({{(WBW-ABW){1'b0}}, a});
        end
    endtask

    task automatic apply_stimulus(input logic [ABW-1:0] base, input logic [ABW-1:0] rows,
                                  input int lo, input int hi, input int extra_rel);
        int rel;
        logic timed_out;
        clear_stats();
        push_expected(base, rows);
        @(posedge clk); #1;
        base_addr = base; num_rows = rows; start = 1'b1; c0 = cyc;
        timed_out = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            rel = cyc - c0;
            start = (rel == extra_rel);
            if (rel == extra_rel) begin
                base_addr = 11'h200; num_rows = 11'd1;
            end
            l0_ready = !(rel >= lo && rel <= hi);
            if (done_count > 0 && rel > done_rel + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0; l0_ready = 1'b1;
        check("timeout", 32'(timed_out), 32'd0);
        check("queues_drained", 32'(exp_addr.size() + exp_data.size()), 32'd0);
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic check_output(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cen"}, 32'(sram_cen), 32'd1);
        check({tag, "_wen"}, 32'(sram_wen), 32'd1);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_wr"}, 32'(l0_wr), 32'd0);
        check({tag, "_in"}, l0_in, 32'd0);
    endtask

    initial begin
        logic got3;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; l0_ready = 1'b1;
        c0 = 0; win_lo = 1000; win_hi = -1;
        clear_stats();
        repeat (3) @(posedge clk);
        #1 check_output("rst");
        reset = 1'b0;

        // Basic transfer with full L0 availability.
        apply_stimulus(11'h010, 11'd4, 1000, -1, -1);
        check("t1_first_rd", 32'(first_rd), 32'd1);
        check("t1_last_rd", 32'(last_rd), 32'd4);
        check("t1_first_wr", 32'(first_wr), 32'd3);
        check("t1_last_wr", 32'(last_wr), 32'd6);
        check("t1_n_wr", 32'(n_wr), 32'd4);
        check("t1_done_rel", 32'(done_rel), 32'd7);
        check("t1_busy_at_done", 32'(busy_at_done), 32'd0);
        check("t1_done_count", 32'(done_count), 32'd1);

        // L0 back-pressure in cycles 4..7.
        win_lo = 5; win_hi = 7;
        apply_stimulus(11'h080, 11'd8, 4, 7, -1);
        win_lo = 1000; win_hi = -1;
        check("t2_n_wr", 32'(n_wr), 32'd8);
        check("t2_n_rd", 32'(n_rd), 32'd8);
        check("t2_max_hold_le2", 32'(max_hold <= 2), 32'd1);
        check("t2_reads_stalled", 32'(rd_win), 32'd0);
        check("t2_done_after_last", 32'(done_rel), 32'(last_wr + 1));

        // Address wrap from all-ones to zero.
        apply_stimulus(11'h7FE, 11'd4, 1000, -1, -1);
        check("t3_n_rd", 32'(n_rd), 32'd4);
        check("t3_n_wr", 32'(n_wr), 32'd4);

        // Zero-length transfer.
        apply_stimulus(11'h055, 11'd0, 1000, -1, -1);
        check("t4_done_rel", 32'(done_rel), 32'd1);
        check("t4_busy_seen", 32'(busy_seen), 32'd0);
        check("t4_n_rd", 32'(n_rd), 32'd0);

        // Reset in the middle of a transfer after three writes.
        clear_stats();
        push_expected(11'h020, 11'd8);
        @(posedge clk); #1;
        base_addr = 11'h020; num_rows = 11'd8; start = 1'b1; c0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        got3 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (n_wr == 3) begin
                got3 = 1'b1;
                break;
            end
        end
        check("t5_reached_3_writes", 32'(got3), 32'd1);
        #1 reset = 1'b1;
        #1 check_output("t5_rst");
        exp_addr.delete(); exp_data.delete();
        @(posedge clk); #2 reset = 1'b0;
        clear_stats();
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_done", 32'(done_count), 32'd0);
        check("t5_no_reads", 32'(n_rd), 32'd0);
        check("t5_no_writes", 32'(n_wr), 32'd0);
        apply_stimulus(11'h100, 11'd2, 1000, -1, -1);
        check("t5_restart_n_wr", 32'(n_wr), 32'd2);
        check("t5_restart_done_rel", 32'(done_rel), 32'd5);

        // Second start while busy must be ignored.
        apply_stimulus(11'h040, 11'd4, 1000, -1, 2);
        check("t6_n_wr", 32'(n_wr), 32'd4);
        check("t6_n_rd", 32'(n_rd), 32'd4);
        check("t6_done_rel", 32'(done_rel), 32'd7);
        check("t6_done_count", 32'(done_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
